// File: rtl/softex_x_buffer_ctrl.sv
// rtl/softex_x_buffer_ctrl.sv - x-operand replay buffer sequencer for one softex job
module softex_x_buffer_ctrl #(
    parameter int CNT_WIDTH = 8,
    parameter int VEC_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] cfg_num_loops_i,
    input  logic [VEC_WIDTH-1:0] cfg_num_vectors_i,
    input  logic                 buf_hs_i,
    output logic                 loop_o,
    output logic [CNT_WIDTH-1:0] num_loops_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cur_rep_o,
    output logic [VEC_WIDTH-1:0] cur_vec_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_loops_q, num_loops_d;
    logic [VEC_WIDTH-1:0] num_vectors_q, num_vectors_d;
    logic [CNT_WIDTH-1:0] rep_q, rep_d;
    logic [VEC_WIDTH-1:0] vec_q, vec_d;
    logic                 err_q, err_d;

    // Last-replay / last-vector decodes; latched counts are >= 1 whenever RUN uses them
    logic last_rep;
    logic last_vec;
    assign last_rep = (rep_q == num_loops_q - CNT_WIDTH'(1));
    assign last_vec = (vec_q == num_vectors_q - VEC_WIDTH'(1));

    // Next-state and counter update; clear overrides every other event in the cycle
    always_comb begin
        state_d       = state_q;
        num_loops_d   = num_loops_q;
        num_vectors_d = num_vectors_q;
        rep_d         = rep_q;
        vec_d         = vec_q;
        err_d         = err_q;

        if (clear_i) begin
            state_d       = IDLE;
            num_loops_d   = '0;
            num_vectors_d = '0;
            rep_d         = '0;
            vec_d         = '0;
            err_d         = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        num_loops_d   = cfg_num_loops_i;
                        num_vectors_d = cfg_num_vectors_i;
                        rep_d         = '0;
                        vec_d         = '0;
                        err_d         = 1'b0;
                        // A zero count means no handshakes will ever arrive
                        if ((cfg_num_loops_i == '0) || (cfg_num_vectors_i == '0)) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                    // A handshake here is a protocol violation even alongside a start
                    if (buf_hs_i) begin
                        err_d = 1'b1;
                    end
                end
                RUN: begin
                    if (buf_hs_i) begin
                        if (last_rep) begin
                            rep_d = '0;
                            vec_d = vec_q + VEC_WIDTH'(1);
                            if (last_vec) begin
                                state_d = DONE;
                            end
                        end else begin
                            rep_d = rep_q + CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    if (buf_hs_i) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            num_loops_q   <= '0;
            num_vectors_q <= '0;
            rep_q         <= '0;
            vec_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_loops_q   <= num_loops_d;
            num_vectors_q <= num_vectors_d;
            rep_q         <= rep_d;
            vec_q         <= vec_d;
            err_q         <= err_d;
        end
    end

    // Outputs decode only from state and registers
    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign loop_o      = (state_q == RUN) && (num_loops_q > CNT_WIDTH'(1));
    assign num_loops_o = num_loops_q;
    assign cur_rep_o   = rep_q;
    assign cur_vec_o   = vec_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_softex_x_buffer_ctrl.sv
// tb/tb_softex_x_buffer_ctrl.sv - self-checking bench for softex_x_buffer_ctrl
module tb_softex_x_buffer_ctrl;

    localparam int CW = 8;
    localparam int VW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] cfg_num_loops_i = '0;
    logic [VW-1:0] cfg_num_vectors_i = '0;
    logic          buf_hs_i = 1'b0;
    logic          loop_o;
    logic [CW-1:0] num_loops_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] cur_rep_o;
    logic [VW-1:0] cur_vec_o;
    logic          err_o;

    softex_x_buffer_ctrl #(.CNT_WIDTH(CW), .VEC_WIDTH(VW)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .clear_i           (clear_i),
        .start_i           (start_i),
        .cfg_num_loops_i   (cfg_num_loops_i),
        .cfg_num_vectors_i (cfg_num_vectors_i),
        .buf_hs_i          (buf_hs_i),
        .loop_o            (loop_o),
        .num_loops_o       (num_loops_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .cur_rep_o         (cur_rep_o),
        .cur_vec_o         (cur_vec_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: a job is L*V handshakes; progress follows from the handshake total
    bit in_job;     // handshakes are being accepted
    bit fin;        // final cycle of a job (done pulse)
    int m_l, m_v, m_h;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_job = 0; fin = 0; m_l = 0; m_v = 0; m_h = 0; m_err = 0;
    endtask

    task automatic check_all(input string ctx);
        int er, ev;
        er = (m_l == 0) ? 0 : m_h % m_l;
        ev = (m_l == 0) ? 0 : m_h / m_l;
        chk({ctx, ":busy"},  32'(busy_o),      32'(in_job));
        chk({ctx, ":done"},  32'(done_o),      32'(fin));
        chk({ctx, ":loop"},  32'(loop_o),      32'(in_job && m_l > 1));
        chk({ctx, ":nloop"}, 32'(num_loops_o), 32'(m_l));
        chk({ctx, ":rep"},   32'(cur_rep_o),   32'(er));
        chk({ctx, ":vec"},   32'(cur_vec_o),   32'(ev));
        chk({ctx, ":err"},   32'(err_o),       32'(m_err));
    endtask

    // One clock cycle: drive inputs, advance model at the edge, check 1ns later
    task automatic tick(input string ctx, input bit st, input int l, input int v,
                        input bit hs, input bit clr);
        start_i           = st;
        cfg_num_loops_i   = CW'(l);
        cfg_num_vectors_i = VW'(v);
        buf_hs_i          = hs;
        clear_i           = clr;
        @(posedge clk_i);
        if (clr) begin
            model_reset();
        end else if (fin) begin
            fin = 0;
            if (hs) m_err = 1;
        end else if (in_job) begin
            if (hs) begin
                m_h++;
                if (m_h == m_l * m_v) begin
                    in_job = 0;
                    fin    = 1;
                end
            end
        end else begin
            if (st) begin
                m_l = l; m_v = v; m_h = 0; m_err = 0;
                if (l == 0 || v == 0) fin = 1;
                else in_job = 1;
            end
            if (hs) m_err = 1;
        end
        #1;
        start_i  = 0;
        buf_hs_i = 0;
        clear_i  = 0;
        check_all(ctx);
    endtask

    initial begin
        int n;
        bit hs;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic job: 3 loops x 2 vectors, back-to-back handshakes
        tick("basic_start", 1, 3, 2, 0, 0);
        for (int i = 0; i < 6; i++) tick("basic_hs", 0, 0, 0, 1, 0);
        chk("basic_done_pulse", 32'(done_o), 32'd1);
        chk("basic_final_vec", 32'(cur_vec_o), 32'd2);
        tick("basic_idle", 0, 0, 0, 0, 0);

        // Pass-through with random gaps
        tick("pt_start", 1, 1, 4, 0, 0);
        n = 0;
        while (in_job && n < 100) begin
            tick("pt_run", 0, 0, 0, ($urandom_range(0, 2) == 0), 0);
            n++;
        end
        chk("pt_bound", 32'(n < 100), 32'd1);
        tick("pt_idle", 0, 0, 0, 0, 0);

        // Degenerate configurations
        tick("deg_l0", 1, 0, 5, 0, 0);
        tick("deg_l0_idle", 0, 0, 0, 0, 0);
        tick("deg_v0", 1, 3, 0, 0, 0);
        tick("deg_v0_idle", 0, 0, 0, 0, 0);

        // Start ignored while busy
        tick("ign_start", 1, 2, 2, 0, 0);
        tick("ign_hs1", 0, 0, 0, 1, 0);
        tick("ign_restart", 1, 7, 9, 0, 0);
        chk("ign_nloop_kept", 32'(num_loops_o), 32'd2);
        for (int i = 0; i < 3; i++) tick("ign_hs", 0, 0, 0, 1, 0);
        tick("ign_idle", 0, 0, 0, 0, 0);

        // Clear coincident with a handshake mid-job, then a fresh job
        tick("clr_start", 1, 3, 2, 0, 0);
        for (int i = 0; i < 3; i++) tick("clr_hs", 0, 0, 0, 1, 0);
        tick("clr_hit", 0, 0, 0, 1, 1);
        chk("clr_no_done", 32'(done_o), 32'd0);
        tick("clr_fresh", 1, 2, 1, 0, 0);
        tick("clr_fresh_hs", 0, 0, 0, 1, 0);
        tick("clr_fresh_hs", 0, 0, 0, 1, 0);
        tick("clr_fresh_idle", 0, 0, 0, 0, 0);

        // Protocol error in IDLE: sticky until the next accepted start
        tick("err_hs", 0, 0, 0, 1, 0);
        chk("err_set", 32'(err_o), 32'd1);
        tick("err_hold", 0, 0, 0, 0, 0);
        tick("err_start", 1, 2, 2, 0, 0);
        chk("err_cleared", 32'(err_o), 32'd0);
        tick("arst_hs", 0, 0, 0, 1, 0);

        // Asynchronous reset mid-RUN takes effect without a clock edge
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized jobs with stray starts, stray handshakes and occasional clears
        for (int j = 0; j < 30; j++) begin
            tick("rnd_start", 1, $urandom_range(0, 4), $urandom_range(0, 4), 0, 0);
            n = 0;
            while ((in_job || fin) && n < 100) begin
                hs = ($urandom_range(0, 2) != 0);
                tick("rnd_run", ($urandom_range(0, 9) == 0), $urandom_range(0, 7),
                     $urandom_range(0, 7), hs, ($urandom_range(0, 39) == 0));
                n++;
            end
            chk("rnd_bound", 32'(n < 100), 32'd1);
            if ($urandom_range(0, 3) == 0) tick("rnd_stray", 0, 0, 0, 1, 0);
            tick("rnd_idle", 0, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
